// File: rtl/pupil_line_sequencer.sv
// ============================================================================
// pupil_line_sequencer : fetches one frame-buffer row per detector request
//                        and presents it as a packed line word.
// Revision 1.0
// ============================================================================
`default_nettype none

module pupil_line_sequencer #(
  parameter int MAX_RESOLUTION = 112,
  parameter int ADDR_WIDTH     = 14
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_capture_done,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [7:0]                  mem_rd_data,
  output logic                        frame_start,
  input  logic                        line_req,
  input  logic [7:0]                  line_req_num,
  output logic [MAX_RESOLUTION*8-1:0] line_data,
  output logic                        line_valid,
  output logic                        line_err,
  input  logic                        detect_done,
  output logic                        busy,
  output logic [7:0]                  frames_dropped
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_PRESENT = 3'd5;

  localparam logic [7:0]            LAST_COL   = 8'(MAX_RESOLUTION - 1);
  localparam logic [8:0]            ROW_LIMIT  = 9'(MAX_RESOLUTION);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(MAX_RESOLUTION);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [7:0]            col;
  logic [7:0]            col_d;
  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  row_in_range;
  logic                  start_fetch;

  logic                  rd_en_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  start_nxt;
  logic                  valid_nxt;
  logic                  err_nxt;
  logic                  busy_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    row_in_range = ({1'b0, line_req_num} < ROW_LIMIT);
    req_base     = ADDR_WIDTH'(line_req_num) * ROW_STRIDE;
    next_state   = state;
    case (state)
      S_IDLE:    if (frame_capture_done) next_state = S_START;
      S_START:   next_state = S_WAIT;
      // detect_done wins over a request arriving in the same cycle
      S_WAIT: begin
        if (detect_done)                  next_state = S_IDLE;
        else if (line_req && row_in_range) next_state = S_FETCH;
      end
      S_FETCH:   if (col == LAST_COL) next_state = S_DRAIN;
      S_DRAIN:   next_state = S_PRESENT;
      S_PRESENT: next_state = S_WAIT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle early here and registered below.
  always_comb begin
    start_fetch = (state == S_WAIT) && (next_state == S_FETCH);
    rd_en_nxt   = 1'b0;
    addr_nxt    = '0;
    start_nxt   = (next_state == S_START);
    valid_nxt   = (next_state == S_PRESENT);
    busy_nxt    = (next_state != S_IDLE);
    err_nxt     = (state == S_WAIT) && !detect_done && line_req && !row_in_range;
    if (start_fetch) begin
      rd_en_nxt = 1'b1;
      addr_nxt  = req_base;
    end else if ((state == S_FETCH) && (col != LAST_COL)) begin
      rd_en_nxt = 1'b1;
      addr_nxt  = row_base + ADDR_WIDTH'(col + 8'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      frame_start <= 1'b0;
      line_valid  <= 1'b0;
      line_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_rd_en   <= rd_en_nxt;
      mem_rd_addr <= addr_nxt;
      frame_start <= start_nxt;
      line_valid  <= valid_nxt;
      line_err    <= err_nxt;
      busy        <= busy_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col      <= '0;
      col_d    <= '0;
      rd_en_d  <= 1'b0;
      row_base <= '0;
    end else begin
      col_d   <= col;
      rd_en_d <= mem_rd_en;
      if (start_fetch) begin
        col      <= '0;
        row_base <= req_base;
      end else if (state == S_FETCH) begin
        col <= col + 8'd1;
      end
    end
  end

  // Read data lags the strobe by one cycle, so capture uses the delayed column.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_data <= '0;
    end else if (rd_en_d) begin
      line_data[{col_d, 3'b000} +: 8] <= mem_rd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frames_dropped <= '0;
    end else if (frame_capture_done && (state != S_IDLE) && (frames_dropped != 8'hFF)) begin
      frames_dropped <= frames_dropped + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pupil_line_sequencer.sv
// ============================================================================
// tb_pupil_line_sequencer : directed self-checking bench for pupil_line_sequencer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pupil_line_sequencer;

  localparam int RES = 112;
  localparam int AW  = 14;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              frame_capture_done = 1'b0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [7:0]        mem_rd_data = 8'h00;
  logic              frame_start;
  logic              line_req = 1'b0;
  logic [7:0]        line_req_num = 8'h00;
  logic [RES*8-1:0]  line_data;
  logic              line_valid;
  logic              line_err;
  logic              detect_done = 1'b0;
  logic              busy;
  logic [7:0]        frames_dropped;

  int checks   = 0;
  int failures = 0;

  pupil_line_sequencer #(.MAX_RESOLUTION(RES), .ADDR_WIDTH(AW)) dut (
    .clock              (clock),
    .reset              (reset),
    .frame_capture_done (frame_capture_done),
    .mem_rd_en          (mem_rd_en),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_data        (mem_rd_data),
    .frame_start        (frame_start),
    .line_req           (line_req),
    .line_req_num       (line_req_num),
    .line_data          (line_data),
    .line_valid         (line_valid),
    .line_err           (line_err),
    .detect_done        (detect_done),
    .busy               (busy),
    .frames_dropped     (frames_dropped)
  );

  always #5 clock = ~clock;

  // Frame buffer preloaded with byte(addr) = addr[7:0], one-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    frame_capture_done = 1'b1;
    tick();
    frame_capture_done = 1'b0;
    check_eq("frame_start_pulse", {63'd0, frame_start}, 64'd1);
    check_eq("busy_in_start", {63'd0, busy}, 64'd1);
    tick();
    check_eq("frame_start_single", {63'd0, frame_start}, 64'd0);
  endtask

  function automatic int bad_bytes(input int row);
    int bad = 0;
    for (int c = 0; c < RES; c++) begin
      if (line_data[c*8 +: 8] !== 8'(row*RES + c)) bad++;
    end
    return bad;
  endfunction

  // Observes cycles T+1 .. T+115; returns with the block back in WAIT_REQ.
  task automatic fetch_row(input int row, input bit poke);
    int en_cnt = 0, bad_addr = 0, valid_cnt = 0, valid_at = -1;
    int first_addr = -1, last_addr = -1;
    line_req     = 1'b1;
    line_req_num = 8'(row);
    tick();
    line_req = 1'b0;
    for (int n = 1; n <= RES + 3; n++) begin
      if (n > 1) tick();
      if (mem_rd_en) begin
        en_cnt++;
        if (first_addr < 0) first_addr = int'(mem_rd_addr);
        last_addr = int'(mem_rd_addr);
        if (int'(mem_rd_addr) != row*RES + n - 1) bad_addr++;
      end
      if (line_valid) begin
        valid_cnt++;
        valid_at = n;
      end
      if (poke && n == 40) begin
        line_req     = 1'b1;
        line_req_num = 8'((row + 7) % RES);
      end else if (poke && n == 41) begin
        line_req = 1'b0;
      end
    end
    check_eq($sformatf("row%0d_rd_en_count", row), en_cnt, RES);
    check_eq($sformatf("row%0d_addr_seq_errors", row), bad_addr, 0);
    check_eq($sformatf("row%0d_first_addr", row), first_addr, row*RES);
    check_eq($sformatf("row%0d_last_addr", row), last_addr, row*RES + RES - 1);
    check_eq($sformatf("row%0d_valid_latency", row), valid_at, RES + 2);
    check_eq($sformatf("row%0d_valid_count", row), valid_cnt, 1);
    check_eq($sformatf("row%0d_bad_bytes", row), bad_bytes(row), 0);
  endtask

  task automatic pulse_capture();
    frame_capture_done = 1'b1;
    tick();
    frame_capture_done = 1'b0;
    tick();
  endtask

  initial begin
    logic [RES*8-1:0] saved;
    int en_seen;
    int valid_seen;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check_eq("rst_rd_addr", {50'd0, mem_rd_addr}, 64'd0);
    check_eq("rst_strobes", {61'd0, frame_start, line_valid, line_err}, 64'd0);
    check_eq("rst_dropped", {56'd0, frames_dropped}, 64'd0);
    check_eq("rst_line_data_nonzero", {63'd0, |line_data}, 64'd0);

    // Basic fetch of row 3: addresses 336..447
    start_frame();
    fetch_row(3, 1'b0);

    // Out-of-range row
    saved        = line_data;
    line_req     = 1'b1;
    line_req_num = 8'd112;
    tick();
    line_req = 1'b0;
    check_eq("err_pulse", {63'd0, line_err}, 64'd1);
    check_eq("err_no_rd", {63'd0, mem_rd_en}, 64'd0);
    tick();
    check_eq("err_single", {63'd0, line_err}, 64'd0);
    check_eq("err_no_rd_later", {63'd0, mem_rd_en}, 64'd0);
    check_eq("err_data_kept", {63'd0, line_data !== saved}, 64'd0);

    // Back-to-back at minimum spacing, with ignored mid-fetch requests
    fetch_row(0, 1'b1);
    fetch_row(1, 1'b1);
    fetch_row(111, 1'b0);

    // Dropped frames while busy
    repeat (3) pulse_capture();
    check_eq("dropped_3", {56'd0, frames_dropped}, 64'd3);
    check_eq("busy_after_drops", {63'd0, busy}, 64'd1);
    repeat (300) pulse_capture();
    check_eq("dropped_saturate", {56'd0, frames_dropped}, 64'd255);

    // detect_done beats a simultaneous line_req
    detect_done  = 1'b1;
    line_req     = 1'b1;
    line_req_num = 8'd4;
    tick();
    detect_done = 1'b0;
    line_req    = 1'b0;
    en_seen = 0;
    check_eq("done_busy_low", {63'd0, busy}, 64'd0);
    for (int n = 0; n < 10; n++) begin
      if (mem_rd_en) en_seen++;
      tick();
    end
    check_eq("done_no_fetch", en_seen, 0);
    check_eq("done_idle_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a fetch (col = 50)
    start_frame();
    line_req     = 1'b1;
    line_req_num = 8'd2;
    tick();
    line_req = 1'b0;
    repeat (50) tick();
    check_eq("pre_rst_addr_col50", {50'd0, mem_rd_addr}, 64'(2*RES + 50));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check_eq("mid_rst_line_data_nonzero", {63'd0, |line_data}, 64'd0);
    check_eq("mid_rst_dropped", {56'd0, frames_dropped}, 64'd0);
    valid_seen = 0;
    en_seen    = 0;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (line_valid) valid_seen++;
      if (mem_rd_en) en_seen++;
    end
    check_eq("mid_rst_no_valid", valid_seen, 0);
    check_eq("mid_rst_no_rd", en_seen, 0);
    check_eq("mid_rst_data_stays_zero", {63'd0, |line_data}, 64'd0);

    start_frame();
    fetch_row(5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pupil_line_sequencer.md
# pupil_line_sequencer

Controller that feeds the pupil detector one image row at a time. After the camera capture path writes a full frame into the frame-buffer SRAM, the block signals the detector. On each row request it reads that row's MAX_RESOLUTION pixels byte-serially from the SRAM, packs them into one wide line word, and presents it with a single-cycle valid. It owns the frame-buffer read port for the duration of a frame and counts frames that arrive while a frame is still being processed.

## Interface
- MAX_RESOLUTION, 112: pixels per row and rows per frame.
- ADDR_WIDTH, 14: SRAM address width. Must satisfy MAX_RESOLUTION² ≤ 2^ADDR_WIDTH.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_capture_done  in  1  one-cycle pulse: a full frame is in the SRAM.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_WIDTH  SRAM read address: row*MAX_RESOLUTION + col.
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
- frame_start  out  1  one-cycle pulse to the detector: frame available.
- line_req  in  1  detector requests a row. Sampled only in WAIT_REQ.
- line_req_num  in  8  row index of the request.
- line_data  out  MAX_RESOLUTION*8  packed row. Column c occupies bits [8c+7:8c].
- line_valid  out  1  one-cycle pulse: line_data holds the requested row.
- line_err  out  1  one-cycle pulse: requested row number is out of range.
- detect_done  in  1  detector has finished the frame and releases the block.
- busy  out  1  high whenever state ≠ IDLE.
- frames_dropped  out  8  saturating count of ignored frame_capture_done pulses.

## Operation
- States: IDLE, START, WAIT_REQ, FETCH, DRAIN, PRESENT.
- IDLE
  - frame_capture_done → START.
- START
  - frame_start = 1 for exactly this cycle → WAIT_REQ.
- WAIT_REQ
  - detect_done → IDLE. It has priority over a simultaneous line_req.
  - line_req with line_req_num ≥ MAX_RESOLUTION → line_err pulses next cycle; stay in WAIT_REQ.
  - line_req with a valid row → latch row_base = line_req_num*MAX_RESOLUTION, set col = 0 → FETCH.
- FETCH
  - Each cycle: mem_rd_en = 1, mem_rd_addr = row_base + col, col increments.
  - After issuing col = MAX_RESOLUTION-1 → DRAIN.
- Data capture
  - A one-cycle delayed copy of rd_en and col writes mem_rd_data into byte col_d of line_data.
- DRAIN
  - Captures the final byte → PRESENT.
- PRESENT
  - line_valid = 1 → WAIT_REQ.
- line_data
  - Holds its value until the next fetch overwrites it byte by byte.
  - Is not valid mid-fetch.
- line_req outside WAIT_REQ: ignored, not queued.
- frame_capture_done in any state other than IDLE: frame not accepted; frames_dropped += 1, saturating at 255.
- Arithmetic
  - row_base and mem_rd_addr are ADDR_WIDTH wide and never wrap for legal rows.
  - col counter is 8 bits.
- Reset, from any state including mid-FETCH:
  - state = IDLE; line_data = 0; frames_dropped = 0.
  - All strobes (mem_rd_en, frame_start, line_valid, line_err) = 0; mem_rd_addr = 0; busy = 0.
  - No partial line is presented afterwards.

## Timing
- frame_capture_done sampled at cycle F → frame_start high in F+1 → WAIT_REQ from F+2.
- Valid line_req sampled in WAIT_REQ at cycle T:
  - mem_rd_en high T+1 … T+MAX_RESOLUTION.
  - Last byte captured at the end of T+MAX_RESOLUTION+1.
  - line_valid high in T+MAX_RESOLUTION+2 (T+114 at default).
  - Back in WAIT_REQ at T+MAX_RESOLUTION+3.
- Request-to-line latency: MAX_RESOLUTION+2 cycles.
- Back-to-back requests: minimum spacing MAX_RESOLUTION+3 cycles.
- line_err asserted in T+1; block ready again in T+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Basic fetch: SRAM preloaded with byte(addr) = addr[7:0]; frame_capture_done, then line_req_num = 3.
  - Expect frame_start one cycle after the pulse.
  - Expect line_valid exactly 114 cycles after the request.
  - Expect line_data byte c = (336+c)[7:0].
  - Expect mem_rd_addr 336 … 447 in order.
- Out-of-range row: line_req_num = 112 → line_err single pulse; no mem_rd_en; line_data unchanged; a following request for row 0 succeeds.
- Sequencing: rows 0, 1, 111 requested back-to-back at the minimum spacing.
  - Each line_valid carries the correct row.
  - Last row reads addresses 12432 … 12543.
  - line_req pulses sent mid-fetch are ignored.
- Frame handling:
  - detect_done together with line_req → IDLE, no fetch.
  - frame_capture_done pulsed three times while busy → frames_dropped = 3.
  - 300 dropped pulses → frames_dropped = 255.
- Reset mid-FETCH at col = 50: next cycle state IDLE, busy = 0, mem_rd_en = 0, line_data = 0; no line_valid afterwards; a new frame then fetches normally.
